// File: rtl/result_writer_if.sv
// result_writer_if: record handshake and AVMM write-master bus of result_writer
interface result_writer_if #(parameter int NDWORDS = 3);
  logic [31:0] i_baseaddr;
  logic [31:0] i_index;
  logic [32*NDWORDS-1:0] i_data;
  logic i_valid;
  logic o_ready;
  logic o_busy;
  logic o_done;
  logic avm_m0_write;
  logic [31:0] avm_m0_address;
  logic [15:0] avm_m0_writedata;
  logic [1:0] avm_m0_byteenable;
  logic avm_m0_waitrequest;
  modport master (
    input i_baseaddr, i_index, i_data, i_valid, avm_m0_waitrequest,
    output o_ready, o_busy, o_done, avm_m0_write, avm_m0_address, avm_m0_writedata, avm_m0_byteenable
  );
  modport slave (
    output i_baseaddr, i_index, i_data, i_valid, avm_m0_waitrequest,
    input o_ready, o_busy, o_done, avm_m0_write, avm_m0_address, avm_m0_writedata, avm_m0_byteenable
  );
endinterface

// File: rtl/result_writer.sv
// result_writer: writes one NDWORDS x 32-bit record to AVMM as little-endian 16-bit beats
module result_writer #(parameter int NDWORDS = 3) (
  input logic i_clk,
  input logic i_rstn,
  result_writer_if.master bus
);
  localparam int NBEATS = 2*NDWORDS;
  localparam int BW = $clog2(NBEATS);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state, state_nx;
  logic [BW-1:0] beat, beat_nx;
  logic [32*NDWORDS-1:0] data_q, data_nx;
  logic write_q, write_nx, done_q, done_nx;
  logic [31:0] addr_q, addr_nx;
  logic [15:0] wd_q, wd_nx;
  logic last;
  assign last = beat == BW'(NBEATS-1);
  assign bus.o_ready = state == IDLE;
  assign bus.o_busy = state == WRITE;
  assign bus.o_done = done_q;
  assign bus.avm_m0_write = write_q;
  assign bus.avm_m0_address = addr_q;
  assign bus.avm_m0_writedata = wd_q;
  assign bus.avm_m0_byteenable = 2'b11;
  // next state and next bus values; a stalled beat keeps everything as is
  always_comb begin
    state_nx = state;
    beat_nx = beat;
    data_nx = data_q;
    write_nx = write_q;
    addr_nx = addr_q;
    wd_nx = wd_q;
    done_nx = 1'b0;
    if (state == IDLE) begin
      write_nx = 1'b0;
      if (bus.i_valid) begin
        state_nx = WRITE;
        beat_nx = '0;
        data_nx = bus.i_data;
        write_nx = 1'b1;
        addr_nx = bus.i_baseaddr + bus.i_index * 32'(4*NDWORDS);
        wd_nx = bus.i_data[15:0];
      end
    end else if (!bus.avm_m0_waitrequest) begin
      if (last) begin
        state_nx = IDLE;
        beat_nx = '0;
        write_nx = 1'b0;
        done_nx = 1'b1;
      end else begin
        beat_nx = beat + BW'(1);
        addr_nx = addr_q + 32'd2;
        wd_nx = data_q[{beat_nx, 4'd0} +: 16];
      end
    end
  end
  // state, latched record and registered bus outputs
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= IDLE;
      beat <= '0;
      data_q <= '0;
      write_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
      done_q <= 1'b0;
    end else begin
      state <= state_nx;
      beat <= beat_nx;
      data_q <= data_nx;
      write_q <= write_nx;
      addr_q <= addr_nx;
      wd_q <= wd_nx;
      done_q <= done_nx;
    end
  end
endmodule
